// File: rtl/pci_target_burst.sv
// PCI memory target with linear burst, byte enables, initial wait states and window-end disconnect.
// Define PCI_TARGET_PARITY_EN to add Par/Par_oe/Perr generation and checking (Par_in input).
module pci_target_burst #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0014,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        Frame,
    input  logic        Irdy,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        Devsel,
    output logic        Trdy,
    output logic        Stop
`ifdef PCI_TARGET_PARITY_EN
    ,
    input  logic        Par_in,
    output logic        Par,
    output logic        Par_oe,
    output logic        Perr
`endif
);

    localparam int unsigned IW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [3:0]  CMD_RD    = 4'b0110;
    localparam logic [3:0]  CMD_WR    = 4'b0111;
    // Reads carry one extra count for the mandatory AD turnaround cycle.
    localparam logic [3:0]  WR_WAIT   = 4'(WAIT_STATES);
    localparam logic [3:0]  RD_WAIT   = 4'(WAIT_STATES + 1);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, BACKOFF, IGNORE, TURN} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic [IW-1:0] index_reg, index_next;
    logic          is_write_reg, is_write_next;
    logic          devsel_reg, devsel_next;
    logic          trdy_reg, trdy_next;
    logic          stop_reg, stop_next;
    logic          ad_oe_reg, ad_oe_next;
    logic          rd_load, wr_en, go_turn;

    logic [31:0]   offset;
    logic          addr_hit;
    logic [IW-1:0] addr_index;

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    assign offset     = AD_in - BASE_ADDR;
    assign addr_hit   = (offset < WIN_BYTES);
    assign addr_index = offset[IW+1:2];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        index_next    = index_reg;
        is_write_next = is_write_reg;
        devsel_next   = devsel_reg;
        trdy_next     = trdy_reg;
        stop_next     = stop_reg;
        ad_oe_next    = ad_oe_reg;
        rd_load       = 1'b0;
        wr_en         = 1'b0;
        go_turn       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!Frame) begin
                    if (addr_hit && (CBE == CMD_RD || CBE == CMD_WR)) begin
                        is_write_next = (CBE == CMD_WR);
                        index_next    = addr_index;
                        devsel_next   = 1'b0;
                        if (CBE == CMD_WR && WAIT_STATES == 0) begin
                            state_next = DATA;
                            trdy_next  = 1'b0;
                            stop_next  = (addr_index != LAST_IDX);
                        end else begin
                            state_next    = WAIT;
                            wait_cnt_next = (CBE == CMD_WR) ? WR_WAIT : RD_WAIT;
                        end
                    end else begin
                        state_next = IGNORE;
                    end
                end
            end
            WAIT: begin
                if (!is_write_reg) ad_oe_next = 1'b1;
                if (wait_cnt_reg == 4'd1) begin
                    state_next = DATA;
                    trdy_next  = 1'b0;
                    stop_next  = (index_reg != LAST_IDX);
                    rd_load    = !is_write_reg;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            DATA: begin
                if (!Irdy) begin
                    wr_en = is_write_reg && RST;
                    if (index_reg == LAST_IDX) begin
                        // Window end: index is never advanced past the last word.
                        if (Frame) begin
                            go_turn = 1'b1;
                        end else begin
                            state_next = BACKOFF;
                            trdy_next  = 1'b1;
                        end
                    end else begin
                        index_next = index_reg + 1'b1;
                        if (Frame) begin
                            go_turn = 1'b1;
                        end else begin
                            rd_load   = !is_write_reg;
                            stop_next = (index_next != LAST_IDX);
                        end
                    end
                end
            end
            BACKOFF: begin
                if (Frame) go_turn = 1'b1;
            end
            IGNORE: begin
                if (Frame && Irdy) state_next = IDLE;
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (go_turn) begin
            state_next  = TURN;
            devsel_next = 1'b1;
            trdy_next   = 1'b1;
            stop_next   = 1'b1;
            ad_oe_next  = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!RST) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            index_reg    <= '0;
            is_write_reg <= 1'b0;
            devsel_reg   <= 1'b1;
            trdy_reg     <= 1'b1;
            stop_reg     <= 1'b1;
            ad_oe_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            index_reg    <= index_next;
            is_write_reg <= is_write_next;
            devsel_reg   <= devsel_next;
            trdy_reg     <= trdy_next;
            stop_reg     <= stop_next;
            ad_oe_reg    <= ad_oe_next;
        end
    end

    // One byte-wide RAM per lane so each byte enable maps to its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge Clock) begin
                if (wr_en && !CBE[gi]) mem[index_reg] <= AD_in[8*gi +: 8];
            end

            always_ff @(posedge Clock) begin
                if (!RST) rd_reg <= '0;
                else if (rd_load) rd_reg <= mem[index_next];
            end

            assign AD_out[8*gi +: 8] = rd_reg;
        end
    endgenerate

    assign AD_oe  = ad_oe_reg;
    assign Devsel = devsel_reg;
    assign Trdy   = trdy_reg;
    assign Stop   = stop_reg;

`ifdef PCI_TARGET_PARITY_EN
    logic par_reg, par_oe_reg, perr_reg, wr_par_reg, wr_chk_reg;

    always_ff @(posedge Clock) begin
        if (!RST) begin
            par_reg    <= 1'b0;
            par_oe_reg <= 1'b0;
            perr_reg   <= 1'b1;
            wr_par_reg <= 1'b0;
            wr_chk_reg <= 1'b0;
        end else begin
            par_oe_reg <= ad_oe_reg;
            if (state_reg == DATA && !Irdy && !is_write_reg) par_reg <= ^{AD_out, CBE};
            // Initiator parity arrives one cycle after its data; Perr follows one cycle later.
            wr_chk_reg <= wr_en;
            wr_par_reg <= ^{AD_in, CBE};
            perr_reg   <= !(wr_chk_reg && (wr_par_reg != Par_in));
        end
    end

    assign Par    = par_reg;
    assign Par_oe = par_oe_reg;
    assign Perr   = perr_reg;
`endif

endmodule
